// File: rtl/fetch_pkg.sv
// Shared parameters and state encoding for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam logic [7:0] HALT_OPCODE = 8'hFF;
  localparam logic [ADDR_W-1:0] START_ADDR = '0;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StHold,
    StFlush,
    StHalted
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads one instruction at a time from instruction
// memory, hands it to decode over a valid/ready handshake, follows branch
// redirects and stops on a HALT opcode until restarted.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = fetch_pkg::ADDR_W,
  parameter int unsigned DATA_W = fetch_pkg::DATA_W,
  parameter logic [7:0] HALT_OPCODE = fetch_pkg::HALT_OPCODE,
  parameter logic [ADDR_W-1:0] START_ADDR = fetch_pkg::START_ADDR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  fetch_state_t      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              mem_rd_q;
  logic [DATA_W-1:0] instr_q;
  logic              valid_q;
  logic              halted_q;

  // FSM, program counter and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pc_q     <= START_ADDR;
      mem_rd_q <= 1'b0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            pc_q     <= START_ADDR;
            mem_rd_q <= 1'b1;
            state_q  <= StFetch;
          end
        end
        StFetch: begin
          // Redirect wins over an ack in the same cycle; the ack data is dropped.
          if (redirect) begin
            pc_q     <= redirect_addr;
            mem_rd_q <= 1'b0;
            valid_q  <= 1'b0;
            state_q  <= StFlush;
          end else if (mem_ack) begin
            instr_q  <= mem_data;
            valid_q  <= 1'b1;
            pc_q     <= pc_q + ADDR_W'(1);
            mem_rd_q <= 1'b0;
            state_q  <= StHold;
          end
        end
        StHold: begin
          // A redirect consumes the held instruction without a halt check.
          if (redirect) begin
            pc_q     <= redirect_addr;
            mem_rd_q <= 1'b0;
            valid_q  <= 1'b0;
            state_q  <= StFlush;
          end else if (instr_ready) begin
            valid_q <= 1'b0;
            if (instr_q[DATA_W-1 -: 8] == HALT_OPCODE) begin
              halted_q <= 1'b1;
              state_q  <= StHalted;
            end else begin
              mem_rd_q <= 1'b1;
              state_q  <= StFetch;
            end
          end
        end
        StFlush: begin
          mem_rd_q <= 1'b1;
          state_q  <= StFetch;
        end
        StHalted: begin
          if (start) begin
            halted_q <= 1'b0;
            pc_q     <= START_ADDR;
            mem_rd_q <= 1'b1;
            state_q  <= StFetch;
          end
        end
        default: begin
          state_q  <= StIdle;
          mem_rd_q <= 1'b0;
          valid_q  <= 1'b0;
        end
      endcase
    end
  end

  // The memory address is the PC itself, so it is stable for the whole request.
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign mem_rd      = mem_rd_q;
  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mem_ack;
  logic        instr_ready;
  logic        redirect;
  logic [11:0] redirect_addr;
  logic [31:0] mem_data;

  logic [11:0] mem_addr, pc;
  logic        mem_rd, instr_valid, halted;
  logic [31:0] instr_out;

  logic [11:0] mem_addr_w, pc_w;
  logic        mem_rd_w, instr_valid_w, halted_w;
  logic [31:0] instr_out_w;

  int checks = 0;
  int errors = 0;

  instr_fetch u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .mem_ack      (mem_ack),
    .instr_out    (instr_out),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .halted       (halted),
    .pc           (pc)
  );

  // Second instance starting at the top of the address space for the wrap test
  instr_fetch #(
    .START_ADDR(12'hFFF)
  ) u_dut_wrap (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .mem_addr     (mem_addr_w),
    .mem_rd       (mem_rd_w),
    .mem_data     (mem_data),
    .mem_ack      (mem_ack),
    .instr_out    (instr_out_w),
    .instr_valid  (instr_valid_w),
    .instr_ready  (instr_ready),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .halted       (halted_w),
    .pc           (pc_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0; mem_ack = 1'b0; redirect = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
    redirect = 1'b0; redirect_addr = '0; mem_data = '0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_rd, instr_valid, halted} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {mem_rd, instr_valid, halted});
    end
    checks++;
    if (pc !== 12'h000 || mem_addr !== 12'h000) begin
      errors++; $display("FAIL reset_pc: got pc=%h addr=%h want 000", pc, mem_addr);
    end
    checks++;
    if (instr_out !== 32'h0) begin
      errors++; $display("FAIL reset_instr: got %h want 0", instr_out);
    end
    tick();
    rst_n = 1'b1;
    tick();
    redirect = 1'b1; redirect_addr = 12'h055;
    tick();
    redirect = 1'b0;
    checks++;
    if (pc !== 12'h000 || mem_rd !== 1'b0) begin
      errors++; $display("FAIL idle_redirect: got pc=%h rd=%b want 000 0", pc, mem_rd);
    end
    mem_ack = 1'b1; mem_data = 32'hCAFE0000;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || instr_out !== 32'h0) begin
      errors++; $display("FAIL idle_ack: got v=%b instr=%h want 0 0", instr_valid, instr_out);
    end
  endtask

  task automatic test_basic();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 12'h000) begin
      errors++; $display("FAIL basic_req: got rd=%b addr=%h want 1 000", mem_rd, mem_addr);
    end
    tick();
    checks++;
    if (mem_rd !== 1'b1 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL basic_wait: got rd=%b v=%b want 1 0", mem_rd, instr_valid);
    end
    mem_ack = 1'b1; mem_data = 32'h01000000; instr_ready = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({instr_valid, mem_rd} !== 2'b10 || instr_out !== 32'h01000000 || pc !== 12'h001) begin
      errors++;
      $display("FAIL basic_capture: got v=%b rd=%b instr=%h pc=%h want 1 0 01000000 001",
               instr_valid, mem_rd, instr_out, pc);
    end
    tick();
    checks++;
    if ({instr_valid, mem_rd} !== 2'b01 || mem_addr !== 12'h001) begin
      errors++; $display("FAIL basic_next: got v=%b rd=%b addr=%h want 0 1 001",
                         instr_valid, mem_rd, mem_addr);
    end
  endtask

  task automatic test_latency();
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);  // stray start while fetching must be ignored
      tick();
      start = 1'b0;
      checks++;
      if (mem_rd !== 1'b1 || mem_addr !== 12'h001) begin
        errors++; $display("FAIL latency_wait%0d: got rd=%b addr=%h want 1 001",
                           i, mem_rd, mem_addr);
      end
    end
    mem_ack = 1'b1; mem_data = 32'h12345678;
    tick();
    mem_ack = 1'b0; mem_data = 32'hBAD0BAD0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_out !== 32'h12345678 || mem_rd !== 1'b0) begin
        errors++; $display("FAIL latency_hold%0d: got v=%b instr=%h rd=%b want 1 12345678 0",
                           i, instr_valid, instr_out, mem_rd);
      end
      tick();
    end
    instr_ready = 1'b1;
    tick();
    checks++;
    if ({instr_valid, mem_rd} !== 2'b01 || mem_addr !== 12'h002) begin
      errors++; $display("FAIL latency_release: got v=%b rd=%b addr=%h want 0 1 002",
                         instr_valid, mem_rd, mem_addr);
    end
  endtask

  task automatic test_halt();
    logic [31:0] prog [4];
    prog[0] = 32'h01000000; prog[1] = 32'h02000000;
    prog[2] = 32'h03000000; prog[3] = 32'hFF000000;
    do_reset();
    instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_rd !== 1'b1 || mem_addr !== 12'(i)) begin
        errors++; $display("FAIL halt_req%0d: got rd=%b addr=%h want 1 %h",
                           i, mem_rd, mem_addr, 12'(i));
      end
      tick();
      mem_ack = 1'b1; mem_data = prog[i];
      tick();
      mem_ack = 1'b0;
      checks++;
      if (instr_valid !== 1'b1 || instr_out !== prog[i] || halted !== 1'b0) begin
        errors++; $display("FAIL halt_deliver%0d: got v=%b instr=%h h=%b want 1 %h 0",
                           i, instr_valid, instr_out, halted, prog[i]);
      end
      tick();
      if (i < 3) begin
        checks++;
        if ({mem_rd, instr_valid, halted} !== 3'b100) begin
          errors++; $display("FAIL halt_continue%0d: got %b want 100",
                             i, {mem_rd, instr_valid, halted});
        end
      end else begin
        checks++;
        if ({mem_rd, instr_valid, halted} !== 3'b001 || pc !== 12'h004) begin
          errors++; $display("FAIL halt_stop: got %b pc=%h want 001 004",
                             {mem_rd, instr_valid, halted}, pc);
        end
      end
    end
    redirect = 1'b1; redirect_addr = 12'h077;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({mem_rd, halted} !== 2'b01 || pc !== 12'h004) begin
        errors++; $display("FAIL halt_stay%0d: got rd=%b h=%b pc=%h want 0 1 004",
                           i, mem_rd, halted, pc);
      end
    end
    redirect = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({mem_rd, halted} !== 2'b10 || mem_addr !== 12'h000) begin
      errors++; $display("FAIL halt_restart: got rd=%b h=%b addr=%h want 1 0 000",
                         mem_rd, halted, mem_addr);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    mem_ack = 1'b1; mem_data = 32'hDEADBEEF; redirect = 1'b1; redirect_addr = 12'h0A5;
    tick();
    mem_ack = 1'b0; redirect = 1'b0;
    checks++;
    if ({mem_rd, instr_valid} !== 2'b00 || pc !== 12'h0A5) begin
      errors++; $display("FAIL redir_flush: got rd=%b v=%b pc=%h want 0 0 0a5",
                         mem_rd, instr_valid, pc);
    end
    mem_ack = 1'b1; mem_data = 32'hBEEF0000;  // stray ack during flush
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({mem_rd, instr_valid} !== 2'b10 || mem_addr !== 12'h0A5 || instr_out === 32'hDEADBEEF) begin
      errors++; $display("FAIL redir_refetch: got rd=%b v=%b addr=%h instr=%h want 1 0 0a5",
                         mem_rd, instr_valid, mem_addr, instr_out);
    end
    tick();
    mem_ack = 1'b1; mem_data = 32'hFF000000; instr_ready = 1'b0;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr_out !== 32'hFF000000 || pc !== 12'h0A6) begin
      errors++; $display("FAIL redir_data: got v=%b instr=%h pc=%h want 1 ff000000 0a6",
                         instr_valid, instr_out, pc);
    end
    instr_ready = 1'b1; redirect = 1'b1; redirect_addr = 12'h010;
    tick();
    redirect = 1'b0;
    checks++;
    if ({mem_rd, instr_valid, halted} !== 3'b000 || pc !== 12'h010) begin
      errors++; $display("FAIL redir_hold: got %b pc=%h want 000 010",
                         {mem_rd, instr_valid, halted}, pc);
    end
    tick();
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 12'h010 || halted !== 1'b0) begin
      errors++; $display("FAIL redir_resume: got rd=%b addr=%h h=%b want 1 010 0",
                         mem_rd, mem_addr, halted);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (mem_rd_w !== 1'b1 || mem_addr_w !== 12'hFFF) begin
      errors++; $display("FAIL wrap_first: got rd=%b addr=%h want 1 fff", mem_rd_w, mem_addr_w);
    end
    tick();
    mem_ack = 1'b1; mem_data = 32'h11111111;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (instr_valid_w !== 1'b1 || instr_out_w !== 32'h11111111 || pc_w !== 12'h000) begin
      errors++; $display("FAIL wrap_pc: got v=%b instr=%h pc=%h want 1 11111111 000",
                         instr_valid_w, instr_out_w, pc_w);
    end
    tick();
    checks++;
    if (mem_rd_w !== 1'b1 || mem_addr_w !== 12'h000) begin
      errors++; $display("FAIL wrap_second: got rd=%b addr=%h want 1 000", mem_rd_w, mem_addr_w);
    end
    tick();
    mem_ack = 1'b1; mem_data = 32'h22222222;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (instr_out_w !== 32'h22222222 || pc_w !== 12'h001) begin
      errors++; $display("FAIL wrap_data: got instr=%h pc=%h want 22222222 001",
                         instr_out_w, pc_w);
    end
  endtask

  task automatic test_reset_midfetch();
    do_reset();
    instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (mem_rd !== 1'b1) begin
      errors++; $display("FAIL midreset_pre: got rd=%b want 1", mem_rd);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_rd, instr_valid, halted} !== 3'b000 || pc !== 12'h000 || mem_addr !== 12'h000
        || instr_out !== 32'h0) begin
      errors++; $display("FAIL midreset_async: got %b pc=%h addr=%h instr=%h want 000 000 000 0",
                         {mem_rd, instr_valid, halted}, pc, mem_addr, instr_out);
    end
    #2;
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_data = 32'h55555555;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({mem_rd, instr_valid} !== 2'b00 || instr_out !== 32'h0) begin
      errors++; $display("FAIL midreset_lateack: got rd=%b v=%b instr=%h want 0 0 0",
                         mem_rd, instr_valid, instr_out);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (mem_rd !== 1'b0 || pc !== 12'h000) begin
        errors++; $display("FAIL midreset_idle%0d: got rd=%b pc=%h want 0 000", i, mem_rd, pc);
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 12'h000) begin
      errors++; $display("FAIL midreset_start: got rd=%b addr=%h want 1 000", mem_rd, mem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_halt();
    test_redirect();
    test_wrap();
    test_reset_midfetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The parameter ADDR_W SHALL be 12: program counter and memory address width.
REQ-002 The parameter DATA_W SHALL be 32: instruction width.
REQ-003 The parameter HALT_OPCODE SHALL be 8'hFF: value of instruction bits [31:24] that stops fetch.
REQ-004 The parameter START_ADDR SHALL be 0: PC value loaded on reset and on Start.
REQ-005 Clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 nReset  input  1  asynchronous, active-low reset.
REQ-007 Start  input  1  single-cycle pulse that begins fetching at START_ADDR.
REQ-008 MemAddr  output  ADDR_W  instruction-memory address, equal to the PC while MemRd=1.
REQ-009 MemRd  output  1  memory read request, held until acknowledged.
REQ-010 MemData  input  DATA_W  read data, valid only when MemAck=1.
REQ-011 MemAck  input  1  one-cycle read acknowledge; latency is unbounded (>=1 cycle after MemRd).
REQ-012 InstrOut  output  DATA_W  fetched instruction to decode.
REQ-013 InstrValid  output  1  InstrOut valid.
REQ-014 InstrReady  input  1  decode accepts; handshake completes when InstrValid and InstrReady are both 1 on a rising edge.
REQ-015 Redirect  input  1  branch taken from execute.
REQ-016 RedirectAddr  input  ADDR_W  new PC, sampled when Redirect=1.
REQ-017 Halted  output  1  fetch stopped on HALT_OPCODE.
REQ-018 Pc  output  ADDR_W  current program counter.

Function
REQ-019 The FSM SHALL have the states IDLE, FETCH, HOLD, FLUSH and HALTED, all outputs registered.
REQ-020 In IDLE, MemRd=0 and InstrValid=0; Start=1 SHALL load PC=START_ADDR and enter FETCH, so MemRd=1 in the next cycle.
REQ-021 In FETCH, MemRd=1 and MemAddr=Pc SHALL be held stable until MemAck=1.
REQ-022 On MemAck=1 in FETCH: InstrOut<=MemData, InstrValid<=1, PC<=PC+1 modulo 2^ADDR_W (wraps 12'hFFF to 12'h000), state HOLD, MemRd<=0.
REQ-023 In HOLD, InstrOut and InstrValid SHALL be held stable until the handshake completes.
REQ-024 On handshake in HOLD: if InstrOut[31:24]==HALT_OPCODE the block SHALL enter HALTED, else FETCH; InstrValid<=0, or it stays 1 only if a new instruction is captured in the same cycle (this cannot occur, so the result is 0).
REQ-025 The HALT instruction itself SHALL be delivered to decode before Halted asserts; Halted=1 SHALL assert in the cycle after its handshake.
REQ-026 In HALTED, MemRd=0 and InstrValid=0; Start=1 SHALL clear Halted, load START_ADDR and enter FETCH; all other inputs are ignored.
REQ-027 Redirect=1 in FETCH or HOLD SHALL set PC<=RedirectAddr, InstrValid<=0, MemRd<=0 and state FLUSH; a MemAck in that same cycle is discarded.
REQ-028 Redirect SHALL have priority over a simultaneous handshake in HOLD: the instruction counts as consumed, but no halt check is made.
REQ-029 FLUSH SHALL last exactly one cycle with MemRd=0, ignoring MemAck, then enter FETCH.
REQ-030 Redirect in IDLE, FLUSH or HALTED SHALL be ignored.
REQ-031 Start outside IDLE/HALTED SHALL be ignored.
REQ-032 Best-case throughput is one instruction per 3 cycles (FETCH with ack, HOLD with ready, FETCH).

Reset
REQ-033 nReset=0 SHALL immediately force state IDLE, Pc=START_ADDR, MemAddr=START_ADDR, MemRd=0, InstrOut=0, InstrValid=0, Halted=0, regardless of Clk.
REQ-034 A reset in the middle of a fetch SHALL abandon the request; a MemAck arriving after reset release while in IDLE SHALL be ignored.

Structure
REQ-035 The package fetch_pkg SHALL hold ADDR_W, DATA_W, HALT_OPCODE, START_ADDR and the state enum fetch_state_t.
REQ-036 The block SHALL be a single module with no sub-module; the PC register and the FSM live in instr_fetch.

Verification
REQ-037 Reset then Start, memory with 1-cycle ack returning 32'h01000000 at addr 0 and InstrReady=1 -> MemRd at the cycle after Start, InstrValid 2 cycles later, Pc=1.
REQ-038 Memory latency 5 cycles, InstrReady low for 3 cycles -> MemAddr/MemRd stable for all 5 wait cycles, InstrOut stable while InstrValid=1 and InstrReady=0.
REQ-039 Instruction 32'hFF000000 at addr 3 -> four instructions delivered, Halted=1 the cycle after the 4th handshake, MemRd stays 0; then Start -> fetch resumes at addr 0.
REQ-040 Redirect to 12'h0A5 coincident with MemAck in FETCH -> ack data never appears, one FLUSH cycle with MemRd=0, then MemAddr=12'h0A5.
REQ-041 Start with START_ADDR=12'hFFF, two fetches -> second MemAddr=12'h000.
REQ-042 nReset pulsed low mid-wait (MemRd=1), then a late MemAck -> all outputs at reset values, late ack ignored, IDLE held until Start.
